// File: rtl/imem_pkg.sv
// Shared IMEM constants and the loader state encoding.
package imem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 18;
  localparam int MEM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian 4-byte packer. Byte k of a word lands in bits [8k+7:8k].
// word_nxt is the word as it would look with the current byte merged in, so the
// caller can inspect a completed word on the same cycle as its last byte.
// word_vld pulses one cycle after the 4th byte when in_keep was set, while word
// still holds the completed value.
module imem_byte_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_vld,
  input  logic                  in_keep,
  input  logic [7:0]            in_byte,
  output logic [1:0]            bcnt,
  output logic [DATA_WIDTH-1:0] word_nxt,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_vld
);

  logic [1:0]            bcnt_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic                  vld_q;

  // merge the incoming byte into its lane
  always_comb begin
    word_nxt = asm_q;
    word_nxt[{bcnt_q, 3'b000} +: 8] = in_byte;
  end

  // assembly register, byte lane counter (wraps 3->0) and word-complete flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= 2'd0;
      asm_q  <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      bcnt_q <= 2'd0;
      asm_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_vld & in_keep & (bcnt_q == 2'd3);
      if (in_vld) begin
        asm_q  <= word_nxt;
        bcnt_q <= bcnt_q + 2'd1;
      end
    end
  end

  assign bcnt     = bcnt_q;
  assign word     = asm_q;
  assign word_vld = vld_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte stream -> IMEM write port loader.
// Frame: 4-byte LE word count N, then N LE words. Holds the CPU while loading.
// Optional feature macro: IMEM_LOADER_CSUM_EN appends an XOR checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = imem_pkg::ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  output logic                            byte_ready,
  output logic                            imem_we,
  output logic [ADDR_WIDTH-1:0]           imem_waddr,
  output logic [imem_pkg::DATA_WIDTH-1:0] imem_wdata,
  output logic                            cpu_hold,
  output logic                            load_done,
  output logic                            load_err
);
  import imem_pkg::*;

  // N may equal the depth, so the limit needs one extra bit beyond the address
  localparam logic [32:0] DEPTH_L = 33'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CSUM_EN
  localparam loader_state_t FRAME_END = CSUM;
`else
  localparam loader_state_t FRAME_END = DONE;
`endif

  loader_state_t         state, state_nxt;
  logic                  start_ok, xfer, word_end, last_word, last_q;
  logic [1:0]            bcnt;
  logic [DATA_WIDTH-1:0] len_word;
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH:0]   rcnt, nwords;
  logic                  err_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]            csum_q;
`endif

  assign start_ok = (state == IDLE) & load_start;
`ifdef IMEM_LOADER_CSUM_EN
  assign byte_ready = (state == LEN) | (state == DATA) | (state == CSUM);
`else
  assign byte_ready = (state == LEN) | (state == DATA);
`endif
  assign xfer      = byte_valid & byte_ready;
  assign word_end  = xfer & (bcnt == 2'd3);
  assign last_word = (rcnt == nwords - 1'b1);

  imem_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .in_vld   (xfer),
    .in_keep  (state == DATA),
    .in_byte  (byte_data),
    .bcnt     (bcnt),
    .word_nxt (len_word),
    .word     (imem_wdata),
    .word_vld (imem_we)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_start) state_nxt = LEN;
      LEN: if (word_end) begin
        if ({1'b0, len_word} > DEPTH_L) state_nxt = ERR;
        else if (len_word == '0)        state_nxt = FRAME_END;
        else                            state_nxt = DATA;
      end
      DATA: if (word_end && last_word) state_nxt = FRAME_END;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: if (xfer) state_nxt = (byte_data == csum_q) ? DONE : ERR;
`endif
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // word counters; the write index stops on the last word so it never passes N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx   <= '0;
      rcnt   <= '0;
      nwords <= '0;
      last_q <= 1'b0;
    end else if (start_ok) begin
      widx   <= '0;
      rcnt   <= '0;
      nwords <= '0;
      last_q <= 1'b0;
    end else begin
      last_q <= word_end & (state == DATA) & last_word;
      if (imem_we && !last_q)           widx   <= widx + 1'b1;
      if (word_end && state == DATA)    rcnt   <= rcnt + 1'b1;
      if (word_end && state == LEN)     nwords <= len_word[ADDR_WIDTH:0];
    end
  end

  // sticky error, cleared only by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_q <= 1'b0;
    else if (start_ok)                         err_q <= 1'b0;
    else if (state_nxt == ERR && state != ERR) err_q <= 1'b1;
  end

`ifdef IMEM_LOADER_CSUM_EN
  // running XOR of length and data bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        csum_q <= 8'd0;
    else if (start_ok)                 csum_q <= 8'd0;
    else if (xfer && state != CSUM)    csum_q <= csum_q ^ byte_data;
  end
`endif

  assign imem_waddr = widx;
  assign cpu_hold   = (state != IDLE);
  assign load_done  = (state == DONE);
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_WIDTH=4, so MEM_DEPTH=16).
module tb_imem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, load_start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, cpu_hold, load_done, load_err;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // write log captured away from the clock edge
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  bit            wdone_q[$];
  int            done_cnt;
  logic          prev_done, hold_after_done;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_waddr);
      wd_q.push_back(imem_wdata);
      wdone_q.push_back(load_done);
    end
    if (load_done === 1'b1) done_cnt++;
    if (prev_done === 1'b1) hold_after_done = cpu_hold;
    prev_done = load_done;
  end

  task automatic clr_log();
    wa_q.delete(); wd_q.delete(); wdone_q.delete();
    done_cnt = 0; hold_after_done = 1'b1;
  endtask

  task automatic start_pulse();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // present one byte, wait (bounded) for ready, return imem_we one cycle after the transfer
  task automatic send_byte(input logic [7:0] b, output logic we_seen);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 1'b0;
    we_seen = imem_we;
  endtask

  // length, up to two words, optional checksum byte; random gaps and a stray start on request
  task automatic send_frame(input logic [31:0] len, input int nw, input logic [31:0] w0,
                            input logic [31:0] w1, input bit gaps, input bit mid_start,
                            input bit csum_bad, output logic we7, output logic we11);
    logic [7:0] b[$];
    logic [7:0] x;
    logic [31:0] w;
    logic ws;
    for (int i = 0; i < 4; i++) b.push_back(len[8*i +: 8]);
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) b.push_back(w[8*i +: 8]);
    end
`ifdef IMEM_LOADER_CSUM_EN
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(csum_bad ? 8'h00 : x);
`else
    x = {7'd0, csum_bad};
`endif
    we7 = 1'b0; we11 = 1'b0;
    foreach (b[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (mid_start && i == 5) start_pulse();
      send_byte(b[i], ws);
      if (i == 7)  we7  = ws;
      if (i == 11) we11 = ws;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_s1(input string p, input logic we7, input logic we11);
`ifdef IMEM_LOADER_CSUM_EN
    bit last_with_done = 1'b0;
`else
    bit last_with_done = 1'b1;
`endif
    chk({p, "_lat0"}, we7, 1);
    chk({p, "_lat1"}, we11, 1);
    chk({p, "_nwr"}, wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk({p, "_a0"}, wa_q[0], 0);
      chk({p, "_d0"}, wd_q[0], 32'h0000_0013);
      chk({p, "_a1"}, wa_q[1], 1);
      chk({p, "_d1"}, wd_q[1], 32'h0010_0093);
      chk({p, "_done_w0"}, wdone_q[0], 0);
      chk({p, "_done_w1"}, wdone_q[1], last_with_done);
    end
    chk({p, "_done_cnt"}, done_cnt, 1);
    chk({p, "_hold_after"}, hold_after_done, 0);
    chk({p, "_err"}, load_err, 0);
    chk({p, "_hold"}, cpu_hold, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we7, we11, ws;
    rst_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    clr_log();
    repeat (3) @(negedge clk);
    chk("rst_outs", {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, load_done, load_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", byte_ready, 0);

    // 1: two-word frame
    clr_log();
    start_pulse();
    chk("s1_hold_rise", cpu_hold, 1);
    send_frame(32'd2, 2, 32'h0000_0013, 32'h0010_0093, 0, 0, 0, we7, we11);
    chk_s1("s1", we7, we11);

    // 2: empty frame
    clr_log();
    start_pulse();
    send_frame(32'd0, 0, 0, 0, 0, 0, 0, we7, we11);
    chk("s2_nwr", wa_q.size(), 0);
    chk("s2_done", done_cnt, 1);
    chk("s2_err", load_err, 0);

    // 3: N = MEM_DEPTH+1 -> error, nothing consumed afterwards
    clr_log();
    start_pulse();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h11 : 8'h00, ws);
    repeat (2) @(negedge clk);
    chk("s3_err", load_err, 1);
    chk("s3_done", done_cnt, 0);
    byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("s3_ready", byte_ready, 0);
    byte_valid = 1'b0;
    chk("s3_nwr", wa_q.size(), 0);
    chk("s3_hold", cpu_hold, 0);

    // 4: random stalls and a stray start mid-frame
    clr_log();
    start_pulse();
    send_frame(32'd2, 2, 32'h0000_0013, 32'h0010_0093, 1, 1, 0, we7, we11);
    chk_s1("s4", we7, we11);

    // 5: reset after 6 bytes, then a clean reload
    clr_log();
    start_pulse();
    send_byte(8'h02, ws); send_byte(8'h00, ws); send_byte(8'h00, ws);
    send_byte(8'h00, ws); send_byte(8'h13, ws); send_byte(8'h00, ws);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_outs", {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, load_done, load_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_log();
    start_pulse();
    send_frame(32'd2, 2, 32'h0000_0013, 32'h0010_0093, 0, 0, 0, we7, we11);
    chk_s1("s5", we7, we11);

`ifdef IMEM_LOADER_CSUM_EN
    // 6: wrong checksum -> error, words still written
    clr_log();
    start_pulse();
    send_frame(32'd2, 2, 32'h0000_0013, 32'h0010_0093, 0, 0, 1, we7, we11);
    chk("s6_err", load_err, 1);
    chk("s6_done", done_cnt, 0);
    chk("s6_nwr", wa_q.size(), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
